// File: rtl/qdrc_req_arbiter.sv
// rtl/qdrc_req_arbiter.sv - QDR request stage: buffers user write/read requests, round-robin issues strobes, returns tagged reads.
// Tag FIFO depth is rounded up to a power of two; the outstanding counter enforces MAX_OUTSTANDING.

module qdrc_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk0,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
endmodule

module qdrc_req_arbiter #(
  parameter int DATA_WIDTH      = 36,
  parameter int ADDR_WIDTH      = 21,
  parameter int TAG_WIDTH       = 4,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                          clk0,
  input  logic                          reset,
  input  logic                          phy_rdy,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [2*DATA_WIDTH-1:0]       wr_data,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [TAG_WIDTH-1:0]          rd_tag,
  output logic                          usr_wr_strb,
  output logic                          usr_rd_strb,
  output logic [ADDR_WIDTH-1:0]         usr_addr,
  output logic [2*DATA_WIDTH-1:0]       usr_wr_data,
  input  logic [2*DATA_WIDTH-1:0]       usr_rd_data,
  input  logic                          usr_rd_dvld,
  output logic                          rsp_valid,
  output logic [2*DATA_WIDTH-1:0]       rsp_data,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  output logic [$clog2(MAX_OUTSTANDING):0] rd_outstanding,
  output logic                          err_unexpected
);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TAG_DLOG2 = $clog2(MAX_OUTSTANDING);
  localparam int WF_W      = ADDR_WIDTH + 2*DATA_WIDTH;
  localparam int RF_W      = ADDR_WIDTH + TAG_WIDTH;

  logic                  wr_full, wr_empty, rd_full, rd_empty, tag_full, tag_empty;
  logic [WF_W-1:0]       wr_head;
  logic [RF_W-1:0]       rd_head;
  logic [TAG_WIDTH-1:0]  tag_head;
  logic                  wr_push, rd_push;
  logic                  wr_elig, rd_elig, grant_wr, grant_rd, tag_pop;
  logic                  last_grant_rd;

  // Ready is held low during reset so every output reads 0 while reset is high.
  assign wr_ready = !reset && !wr_full;
  assign rd_ready = !reset && !rd_full;
  assign wr_push  = wr_valid && wr_ready;
  assign rd_push  = rd_valid && rd_ready;

  qdrc_fifo #(.WIDTH(WF_W), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_wr_fifo (
    .clk0(clk0), .reset(reset), .push(wr_push), .push_data({wr_addr, wr_data}),
    .pop(grant_wr), .head(wr_head), .full(wr_full), .empty(wr_empty)
  );

  qdrc_fifo #(.WIDTH(RF_W), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rd_fifo (
    .clk0(clk0), .reset(reset), .push(rd_push), .push_data({rd_addr, rd_tag}),
    .pop(grant_rd), .head(rd_head), .full(rd_full), .empty(rd_empty)
  );

  qdrc_fifo #(.WIDTH(TAG_WIDTH), .DEPTH_LOG2(TAG_DLOG2)) u_tag_fifo (
    .clk0(clk0), .reset(reset), .push(grant_rd), .push_data(rd_head[TAG_WIDTH-1:0]),
    .pop(tag_pop), .head(tag_head), .full(tag_full), .empty(tag_empty)
  );

  assign wr_elig  = phy_rdy && !wr_empty;
  assign rd_elig  = phy_rdy && !rd_empty && (rd_outstanding < OUT_W'(MAX_OUTSTANDING)) && !tag_full;
  // Read wins a tie only when the previous grant went to a write.
  assign grant_rd = rd_elig && (!wr_elig || !last_grant_rd);
  assign grant_wr = wr_elig && !grant_rd;
  assign tag_pop  = usr_rd_dvld && !tag_empty;

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      last_grant_rd  <= 1'b0;
      usr_wr_strb    <= 1'b0;
      usr_rd_strb    <= 1'b0;
      usr_addr       <= '0;
      usr_wr_data    <= '0;
      rd_outstanding <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_tag        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      usr_wr_strb <= grant_wr;
      usr_rd_strb <= grant_rd;
      if (grant_wr) begin
        last_grant_rd <= 1'b0;
        usr_addr      <= wr_head[WF_W-1 -: ADDR_WIDTH];
        usr_wr_data   <= wr_head[2*DATA_WIDTH-1:0];
      end else if (grant_rd) begin
        last_grant_rd <= 1'b1;
        usr_addr      <= rd_head[RF_W-1 -: ADDR_WIDTH];
      end

      case ({grant_rd, tag_pop})
        2'b10:   rd_outstanding <= rd_outstanding + OUT_W'(1);
        2'b01:   rd_outstanding <= rd_outstanding - OUT_W'(1);
        default: rd_outstanding <= rd_outstanding;
      endcase

      rsp_valid <= usr_rd_dvld;
      if (usr_rd_dvld) begin
        rsp_data <= usr_rd_data;
        rsp_tag  <= tag_empty ? '0 : tag_head;
      end
      if (usr_rd_dvld && tag_empty) err_unexpected <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qdrc_req_arbiter.sv
// tb/tb_qdrc_req_arbiter.sv - directed bench for qdrc_req_arbiter with a fixed-latency controller model.
module tb_qdrc_req_arbiter;
  localparam int DW = 36, AW = 21, TW = 4, FL = 3, MO = 16, OW = 5, LAT = 15, NV = 18;

  logic clk0, reset, phy_rdy;
  logic wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, usr_addr;
  logic [2*DW-1:0] wr_data, usr_wr_data, usr_rd_data, rsp_data;
  logic [TW-1:0] rd_tag, rsp_tag;
  logic usr_wr_strb, usr_rd_strb, usr_rd_dvld, rsp_valid, err_unexpected;
  logic [OW-1:0] rd_outstanding;

  int checks = 0;
  int errors = 0;

  logic ctl_en, man_dvld, mon_en, prev_dvld;
  logic [2*DW-1:0] man_data;
  logic [LAT-1:0] ctl_pipe;
  logic [2*DW-1:0] ctl_data [LAT];
  int timing_bad, both_bad;
  logic [OW-1:0] peak;
  logic [TW-1:0] got_tags [$];
  logic [2*DW-1:0] got_data [$];

  typedef struct {
    logic phy, wv, rv, ws, rs;
    logic [OW-1:0] outst;
  } vec_t;
  vec_t vecs [NV];

  qdrc_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                     .FIFO_DEPTH_LOG2(FL), .MAX_OUTSTANDING(MO)) dut (
    .clk0(clk0), .reset(reset), .phy_rdy(phy_rdy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_tag(rd_tag),
    .usr_wr_strb(usr_wr_strb), .usr_rd_strb(usr_rd_strb), .usr_addr(usr_addr),
    .usr_wr_data(usr_wr_data), .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rd_outstanding(rd_outstanding), .err_unexpected(err_unexpected)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Controller: read data returns LAT cycles after the strobe, carrying the read address.
  always @(posedge clk0) begin
    ctl_pipe <= {ctl_pipe[LAT-2:0], usr_rd_strb & ctl_en};
    ctl_data[0] <= (2*DW)'(usr_addr);
    for (int k = 1; k < LAT; k++) ctl_data[k] <= ctl_data[k-1];
  end
  assign usr_rd_dvld = ctl_pipe[LAT-1] | man_dvld;
  assign usr_rd_data = man_dvld ? man_data : ctl_data[LAT-1];

  always @(negedge clk0) begin
    if (mon_en) begin
      if (rsp_valid !== prev_dvld) timing_bad++;
      if (usr_wr_strb && usr_rd_strb) both_bad++;
      if (rsp_valid) begin
        got_tags.push_back(rsp_tag);
        got_data.push_back(rsp_data);
      end
      if (rd_outstanding > peak) peak = rd_outstanding;
    end
    prev_dvld = usr_rd_dvld;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    man_dvld = 1'b0;
    tick();
    tick();
    check("rst_wr_strb", 72'(usr_wr_strb), 72'(0));
    check("rst_rd_strb", 72'(usr_rd_strb), 72'(0));
    check("rst_rsp_valid", 72'(rsp_valid), 72'(0));
    check("rst_outstanding", 72'(rd_outstanding), 72'(0));
    check("rst_err", 72'(err_unexpected), 72'(0));
    check("rst_addr", 72'(usr_addr), 72'(0));
    reset = 1'b0;
    tick();
    check("rel_wr_ready", 72'(wr_ready), 72'(1));
    check("rel_rd_ready", 72'(rd_ready), 72'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; phy_rdy = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; rd_tag = '0;
    ctl_en = 1'b0; man_dvld = 1'b0; man_data = '0; mon_en = 1'b0; prev_dvld = 1'b0;
    ctl_pipe = '0; timing_bad = 0; both_bad = 0; peak = '0;

    //            phy   wv    rv    ws    rs    outstanding
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4};

    // Arbitration and phy_rdy gating table.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      phy_rdy  = vecs[i].phy;
      wr_valid = vecs[i].wv;
      rd_valid = vecs[i].rv;
      wr_addr  = AW'(i);
      wr_data  = (2*DW)'(i);
      rd_addr  = AW'(4096 + i);
      rd_tag   = TW'(i);
      tick();
      check($sformatf("vec%0d_wr_strb", i), 72'(usr_wr_strb), 72'(vecs[i].ws));
      check($sformatf("vec%0d_rd_strb", i), 72'(usr_rd_strb), 72'(vecs[i].rs));
      check($sformatf("vec%0d_outstanding", i), 72'(rd_outstanding), 72'(vecs[i].outst));
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;

    // Single write latency.
    do_reset();
    phy_rdy = 1'b1;
    wr_valid = 1'b1; wr_addr = 21'h1ABCD; wr_data = '1;
    tick();
    wr_valid = 1'b0;
    check("single_strb_k", 72'(usr_wr_strb), 72'(0));
    check("single_wr_ready", 72'(wr_ready), 72'(1));
    tick();
    check("single_strb_k1", 72'(usr_wr_strb), 72'(1));
    check("single_addr", 72'(usr_addr), 72'(21'h1ABCD));
    check("single_data", usr_wr_data, {72{1'b1}});
    tick();
    check("single_strb_k2", 72'(usr_wr_strb), 72'(0));
    check("single_addr_hold", 72'(usr_addr), 72'(21'h1ABCD));

    // Fill the write FIFO with phy_rdy low, then drain in order.
    phy_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(512 + i); wr_data = (2*DW)'(i);
      tick();
      check($sformatf("fill%0d_no_strb", i), 72'(usr_wr_strb), 72'(0));
    end
    wr_valid = 1'b0;
    check("fill_wr_ready_low", 72'(wr_ready), 72'(0));
    phy_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("drain%0d_strb", i), 72'(usr_wr_strb), 72'(1));
      check($sformatf("drain%0d_addr", i), 72'(usr_addr), 72'(512 + i));
    end
    tick();
    check("drain_idle", 72'(usr_wr_strb), 72'(0));
    check("drain_wr_ready", 72'(wr_ready), 72'(1));

    // 20 reads through a 15-cycle controller.
    do_reset();
    phy_rdy = 1'b1; ctl_en = 1'b1; mon_en = 1'b1; peak = '0;
    timing_bad = 0; both_bad = 0;
    for (int i = 0; i < 20; i++) begin
      int guard;
      rd_valid = 1'b1; rd_addr = AW'(256 + i); rd_tag = TW'(i % 16);
      guard = 0;
      while (!rd_ready && guard < 100) begin
        tick();
        guard++;
      end
      check($sformatf("rd%0d_accept_timeout", i), 72'(guard < 100), 72'(1));
      tick();
    end
    rd_valid = 1'b0;
    for (int w = 0; w < 300 && got_tags.size() < 20; w++) tick();
    tick(); tick();
    mon_en = 1'b0;
    check("rsp_count", 72'(got_tags.size()), 72'(20));
    for (int i = 0; i < 20 && i < got_tags.size(); i++) begin
      check($sformatf("rsp%0d_tag", i), 72'(got_tags[i]), 72'(i % 16));
      check($sformatf("rsp%0d_data", i), got_data[i], 72'(256 + i));
    end
    check("rsp_timing", 72'(timing_bad), 72'(0));
    check("never_both_strobes", 72'(both_bad), 72'(0));
    check("peak_outstanding", 72'(peak), 72'(16));
    check("final_outstanding", 72'(rd_outstanding), 72'(0));
    check("no_err_normal", 72'(err_unexpected), 72'(0));
    ctl_en = 1'b0;

    // Unexpected read data with nothing outstanding.
    do_reset();
    man_data = 72'h12_3456_789A_BCDE_F012;
    man_dvld = 1'b1;
    tick();
    man_dvld = 1'b0;
    check("unexp_rsp_valid", 72'(rsp_valid), 72'(1));
    check("unexp_rsp_tag", 72'(rsp_tag), 72'(0));
    check("unexp_rsp_data", rsp_data, 72'h12_3456_789A_BCDE_F012);
    check("unexp_err", 72'(err_unexpected), 72'(1));
    check("unexp_no_underflow", 72'(rd_outstanding), 72'(0));
    tick();
    check("unexp_rsp_pulse", 72'(rsp_valid), 72'(0));
    tick(); tick(); tick();
    check("unexp_err_sticky", 72'(err_unexpected), 72'(1));

    // Reset with reads outstanding and writes queued.
    do_reset();
    phy_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_valid = 1'b1; rd_addr = AW'(64 + i); rd_tag = TW'(i);
      tick();
    end
    rd_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_outstanding", 72'(rd_outstanding), 72'(5));
    phy_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i);
      tick();
    end
    wr_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_wr_strb", 72'(usr_wr_strb), 72'(0));
    check("midrst_rd_strb", 72'(usr_rd_strb), 72'(0));
    check("midrst_outstanding", 72'(rd_outstanding), 72'(0));
    reset = 1'b0;
    phy_rdy = 1'b1;
    both_bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (usr_wr_strb || usr_rd_strb) both_bad++;
    end
    check("post_rst_fifos_empty", 72'(both_bad), 72'(0));
    check("post_rst_wr_ready", 72'(wr_ready), 72'(1));
    check("post_rst_rd_ready", 72'(rd_ready), 72'(1));
    check("post_rst_outstanding", 72'(rd_outstanding), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
